usb_rx_bit_decoder: RTL and testbench

//   Front end of the USB receive path: synchronises raw D+/D- pins, recovers bit timing at

---
 rtl/usb_rx_pkg.sv | 19 +
 rtl/usb_rx_sync.sv | 23 ++
 rtl/usb_rx_bit_decoder.sv | 168 ++++++++++++++++
 tb/tb_usb_rx_bit_decoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and line-state constants for the USB receive front end.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_J
  } state_t;

  typedef enum logic [1:0] {
    LINE_J,
    LINE_K,
    LINE_SE0
  } line_t;

  localparam logic USB_IDLE_DP = 1'b1;
  localparam logic USB_IDLE_DM = 1'b0;

endpackage

// File: rtl/usb_rx_sync.sv
// Two-flop synchroniser for one asynchronous USB pin; RST_VAL sets its idle level.
module usb_rx_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      meta     <= RST_VAL;
      sync_out <= RST_VAL;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// USB RX bit decoder: pin sync, bit-timing recovery, NRZI decode and bit unstuffing.
// Define USB_RX_EDGE_RESYNC_EN to re-centre the sample point on every K<->J line edge.
module usb_rx_bit_decoder
  import usb_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_POINT = 3,
  parameter int unsigned STUFF_LEN    = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic rx_enable,
  input  logic d_plus_in,
  input  logic d_minus_in,
  output logic d_orig,
  output logic shift_enable,
  output logic packet_start,
  output logic eop,
  output logic stuff_err,
  output logic rx_active
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned ONES_W = 3;

  logic dp_s;
  logic dm_s;

  usb_rx_sync #(.RST_VAL(USB_IDLE_DP)) u_sync_dp (
    .clk      (clk),
    .n_rst    (n_rst),
    .async_in (d_plus_in),
    .sync_out (dp_s)
  );

  usb_rx_sync #(.RST_VAL(USB_IDLE_DM)) u_sync_dm (
    .clk      (clk),
    .n_rst    (n_rst),
    .async_in (d_minus_in),
    .sync_out (dm_s)
  );

  state_t              state, state_d;
  line_t               line_c, line_q;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_d;
  logic [ONES_W-1:0]   ones_cnt, ones_d;
  logic                prev_line, prev_line_d;
  logic                d_orig_d, shift_d, start_d, eop_d, err_d;
  logic                nrzi_bit_c;
  logic                sop_c;
  logic                sample_c;

  // Line classification: SE0 when both pins low, otherwise D+ carries the value.
  always_comb begin
    line_c = LINE_J;
    if (!dp_s && !dm_s) begin
      line_c = LINE_SE0;
    end else if (!dp_s) begin
      line_c = LINE_K;
    end
  end

  assign nrzi_bit_c = (dp_s == prev_line);
  assign sop_c      = rx_enable && (line_q == LINE_J) && (line_c == LINE_K);
  assign sample_c   = (bit_cnt == CNT_W'(SAMPLE_POINT));

`ifdef USB_RX_EDGE_RESYNC_EN
  logic edge_c;
  assign edge_c = (line_c != line_q) && (line_c != LINE_SE0) && (line_q != LINE_SE0);
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      line_q       <= LINE_J;
      bit_cnt      <= '0;
      ones_cnt     <= '0;
      prev_line    <= 1'b1;
      d_orig       <= 1'b1;
      shift_enable <= 1'b0;
      packet_start <= 1'b0;
      eop          <= 1'b0;
      stuff_err    <= 1'b0;
      rx_active    <= 1'b0;
    end else begin
      state        <= state_d;
      line_q       <= line_c;
      bit_cnt      <= bit_cnt_d;
      ones_cnt     <= ones_d;
      prev_line    <= prev_line_d;
      d_orig       <= d_orig_d;
      shift_enable <= shift_d;
      packet_start <= start_d;
      eop          <= eop_d;
      stuff_err    <= err_d;
      rx_active    <= (state_d == RUN);
    end
  end

  // Next-state, bit timing, NRZI/unstuff datapath and strobe generation.
  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    ones_d      = ones_cnt;
    prev_line_d = prev_line;
    d_orig_d    = d_orig;
    shift_d     = 1'b0;
    start_d     = 1'b0;
    eop_d       = 1'b0;
    err_d       = 1'b0;

    unique case (state)
      IDLE: begin
        if (sop_c) begin
          state_d     = RUN;
          bit_cnt_d   = '0;
          ones_d      = '0;
          prev_line_d = 1'b1;
          start_d     = 1'b1;
        end
      end
      RUN: begin
        bit_cnt_d = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1)) ? '0 : bit_cnt + CNT_W'(1);
        if (sample_c) begin
          if (line_c == LINE_SE0) begin
            eop_d   = 1'b1;
            state_d = WAIT_J;
          end else begin
            prev_line_d = dp_s;
            if (ones_cnt == ONES_W'(STUFF_LEN)) begin
              if (nrzi_bit_c) begin
                err_d   = 1'b1;
                state_d = WAIT_J;
              end else begin
                ones_d = '0;
              end
            end else begin
              d_orig_d = nrzi_bit_c;
              shift_d  = 1'b1;
              ones_d   = nrzi_bit_c ? ones_cnt + ONES_W'(1) : '0;
            end
          end
        end
`ifdef USB_RX_EDGE_RESYNC_EN
        if (edge_c) begin
          bit_cnt_d = '0;
        end
`endif
      end
      WAIT_J: begin
        if (dp_s == USB_IDLE_DP && dm_s == USB_IDLE_DM) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disabling the receiver abandons any bit in progress.
    if (!rx_enable) begin
      state_d = IDLE;
      shift_d = 1'b0;
      start_d = 1'b0;
      eop_d   = 1'b0;
      err_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Randomised bench for usb_rx_bit_decoder: encodes bit streams onto the pins and
// compares the decoded output with the source data and a timing-level reference.
module tb_usb_rx_bit_decoder;

  localparam int CPB    = 8;
  localparam int SP     = 3;
  localparam int STUFF  = 6;
  localparam int W_J    = 0;
  localparam int W_K    = 1;
  localparam int W_SE0  = 2;
`ifdef USB_RX_EDGE_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst, rx_enable, d_plus_in, d_minus_in;
  logic d_orig, shift_enable, packet_start, eop, stuff_err, rx_active;

  usb_rx_bit_decoder #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(SP), .STUFF_LEN(STUFF)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rx_enable    (rx_enable),
    .d_plus_in    (d_plus_in),
    .d_minus_in   (d_minus_in),
    .d_orig       (d_orig),
    .shift_enable (shift_enable),
    .packet_start (packet_start),
    .eop          (eop),
    .stuff_err    (stuff_err),
    .rx_active    (rx_active)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int wave_q[$];
  bit data_q[$];
  bit got_q[$];
  bit exp_q[$];
  int n_start, n_eop, n_err;
  int exp_start, exp_eop, exp_err;
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Collect decoder output while a waveform is being played.
  always @(negedge clk) begin
    if (mon_en) begin
      if (shift_enable) got_q.push_back(d_orig);
      if (packet_start) n_start++;
      if (eop) n_eop++;
      if (stuff_err) n_err++;
      if (eop || stuff_err) check("eop_err_excl", 32'(eop & stuff_err), 32'd0);
    end
  end

  task automatic drive(input int code);
    d_plus_in  = (code == W_J);
    d_minus_in = (code == W_K);
  endtask

  function automatic int bit_period(input int mode, input int n);
    case (mode)
      1:       return CPB + 1;
      2:       return (n % 2 == 1) ? CPB + 1 : CPB - 1;
      default: return CPB;
    endcase
  endfunction

  function automatic int diff_q(input bit a[$], input bit b[$]);
    int d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int k = 0; k < a.size() && k < b.size(); k++) if (a[k] != b[k]) d++;
    return d;
  endfunction

  task automatic make_data(input int nrand, input int style);
    data_q.delete();
    for (int k = 0; k < 7; k++) data_q.push_back(1'b0);
    data_q.push_back(1'b1);
    for (int k = 0; k < nrand; k++) begin
      if (style == 0) data_q.push_back(1'($urandom_range(0, 3) != 0));
      else            data_q.push_back((k % 3 == 2) ? 1'b0 : 1'($urandom_range(0, 1)));
    end
  endtask

  // Stuff (optionally), NRZI-encode and expand to one line code per clock.
  task automatic build_wave(input int mode, input bit do_stuff);
    bit raw_q[$];
    int ones = 0;
    int line = W_J;
    int nraw = 0;
    wave_q.delete();
    foreach (data_q[k]) begin
      raw_q.push_back(data_q[k]);
      ones = data_q[k] ? ones + 1 : 0;
      if (do_stuff && ones == STUFF) begin
        raw_q.push_back(1'b0);
        ones = 0;
      end
    end
    repeat (6) wave_q.push_back(W_J);
    foreach (raw_q[k]) begin
      if (!raw_q[k]) line = (line == W_J) ? W_K : W_J;
      repeat (bit_period(mode, nraw)) wave_q.push_back(line);
      nraw++;
    end
    repeat (2) begin
      repeat (bit_period(mode, nraw)) wave_q.push_back(W_SE0);
      nraw++;
    end
    repeat (bit_period(mode, nraw) + 12) wave_q.push_back(W_J);
  endtask

  // Reference: sample instants are SP+1 clocks after the SOP edge (or the latest
  // line edge when re-centring), then every CPB clocks; decode NRZI and unstuff.
  task automatic model_run();
    int t0 = -1;
    int nxt, ones;
    bit prev, lv, b, done;
    exp_q.delete();
    exp_start = 0; exp_eop = 0; exp_err = 0;
    for (int i = 1; i < wave_q.size(); i++)
      if (t0 < 0 && wave_q[i-1] == W_J && wave_q[i] == W_K) t0 = i;
    if (t0 >= 0) begin
      exp_start = 1;
      nxt = t0 + SP + 1; prev = 1'b1; ones = 0; done = 1'b0;
      for (int i = t0 + 1; i < wave_q.size() && !done; i++) begin
        if (i == nxt) begin
          nxt += CPB;
          if (wave_q[i] == W_SE0) begin
            exp_eop = 1; done = 1'b1;
          end else begin
            lv = (wave_q[i] == W_J);
            b  = (lv == prev);
            prev = lv;
            if (ones == STUFF) begin
              if (b) begin exp_err = 1; done = 1'b1; end
              else ones = 0;
            end else begin
              exp_q.push_back(b);
              ones = b ? ones + 1 : 0;
            end
          end
        end
        if (RESYNC && wave_q[i] != W_SE0 && wave_q[i-1] != W_SE0 && wave_q[i] != wave_q[i-1])
          nxt = i + SP + 1;
      end
    end
  endtask

  task automatic run_wave(input int drop_at);
    got_q.delete();
    n_start = 0; n_eop = 0; n_err = 0;
    mon_en = 1'b1;
    foreach (wave_q[i]) begin
      @(negedge clk);
      if (i == drop_at) rx_enable = 1'b0;
      if (drop_at >= 0 && i == drop_at + 1) check("drop_rx_active", 32'(rx_active), 32'd0);
      drive(wave_q[i]);
    end
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
  endtask

  task automatic check_vs_model(input string tag);
    check({tag, "_start"}, n_start, exp_start);
    check({tag, "_eop"}, n_eop, exp_eop);
    check({tag, "_stufferr"}, n_err, exp_err);
    check({tag, "_bits_vs_ref"}, diff_q(got_q, exp_q), 0);
    check({tag, "_idle_after"}, 32'(rx_active), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit pre_q[$];
    n_rst = 1'b0; rx_enable = 1'b1; drive(W_J);
    repeat (3) @(negedge clk);
    check("rst_rx_active", 32'(rx_active), 32'd0);
    check("rst_d_orig", 32'(d_orig), 32'd1);
    check("rst_strobes", 32'({shift_enable, packet_start, eop, stuff_err}), 32'd0);
    n_rst = 1'b1;

    // Idle J for 20 cycles.
    wave_q.delete();
    repeat (20) wave_q.push_back(W_J);
    run_wave(-1);
    check("idle_strobes", n_start + n_eop + n_err + got_q.size(), 0);
    check("idle_rx_active", 32'(rx_active), 32'd0);
    check("idle_d_orig", 32'(d_orig), 32'd1);

    // SYNC only: KJKJKJKK then EOP.
    make_data(0, 0);
    build_wave(0, 1'b1); model_run(); run_wave(-1);
    check_vs_model("sync");
    check("sync_bits", diff_q(got_q, data_q), 0);
    check("sync_eop", n_eop, 1);

    // Seven 1s with a stuffed 0 after the sixth.
    make_data(0, 0);
    data_q.push_back(1'b0);
    repeat (7) data_q.push_back(1'b1);
    build_wave(0, 1'b1); model_run(); run_wave(-1);
    check_vs_model("stuffed");
    check("stuffed_bits", diff_q(got_q, data_q), 0);
    check("stuffed_err", n_err, 0);

    // Same run without the stuffed bit: six shifts of 1 then a stuff error.
    build_wave(0, 1'b0); model_run(); run_wave(-1);
    check_vs_model("stufferr");
    pre_q = data_q[0:14];
    check("stufferr_bits", diff_q(got_q, pre_q), 0);
    check("stufferr_err", n_err, 1);
    check("stufferr_eop", n_eop, 0);

    // Random packets biased toward 1s so that stuffing is exercised.
    for (int p = 0; p < 6; p++) begin
      make_data($urandom_range(8, 24), 0);
      build_wave(0, 1'b1); model_run(); run_wave(-1);
      check_vs_model("rand");
      check("rand_bits_vs_data", diff_q(got_q, data_q), 0);
    end

    // Drop rx_enable while data bit 3 is in flight; next packet still starts.
    make_data(8, 0);
    build_wave(0, 1'b1);
    run_wave(6 + 11 * CPB + 2);
    pre_q = data_q[0:10];
    check("drop_bits", diff_q(got_q, pre_q), 0);
    check("drop_eop", n_eop, 0);
    check("drop_start", n_start, 1);
    rx_enable = 1'b1;
    make_data(8, 0);
    build_wave(0, 1'b1); model_run(); run_wave(-1);
    check_vs_model("after_drop");
    check("after_drop_bits", diff_q(got_q, data_q), 0);

    // Reset in the middle of a packet.
    make_data(16, 0);
    build_wave(0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive(wave_q[i]);
    end
    @(negedge clk);
    n_rst = 1'b0; drive(W_J);
    @(negedge clk);
    check("midrst_rx_active", 32'(rx_active), 32'd0);
    check("midrst_d_orig", 32'(d_orig), 32'd1);
    check("midrst_strobes", 32'({shift_enable, packet_start, eop, stuff_err}), 32'd0);
    n_rst = 1'b1;
    wave_q.delete();
    repeat (12) wave_q.push_back(W_J);
    run_wave(-1);
    check("midrst_quiet", n_start + n_eop + n_err + got_q.size(), 0);

    // Clock-rate drift.
    make_data(8, 1);
    if (RESYNC) begin
      build_wave(2, 1'b1); model_run(); run_wave(-1);
      check_vs_model("drift_resync");
      check("drift_resync_bits", diff_q(got_q, data_q), 0);
    end else begin
      build_wave(1, 1'b1); model_run(); run_wave(-1);
      check_vs_model("drift_free");
      check("drift_free_diverges", 32'(diff_q(got_q, data_q) != 0), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
